// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
// ifetch_if : instruction-memory bus plus fetch-to-decode handshake
// Rev 1.0
// ============================================================================
interface ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid, id_instr, id_pc, id_fault,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid, id_instr, id_pc, id_fault,
    output id_ready
  );
endinterface
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// ifetch : credit-based instruction fetch with in-order tag queue and fetch
//          FIFO; optional macro IFETCH_MISALIGN_CHECK_EN flags misaligned PCs
// Rev 1.0
// ============================================================================
module ifetch #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  ifetch_if.master    bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [31:0]   tq_addr [FIFO_DEPTH];
  logic [PW-1:0] tq_wr, tq_rd;
  logic [CW-1:0] tq_cnt;
  logic [31:0]   f_instr [FIFO_DEPTH];
  logic [31:0]   f_pc    [FIFO_DEPTH];
  logic [PW-1:0] f_wr, f_rd;
  logic [CW-1:0] f_cnt;
  logic [CW-1:0] d_cnt;

  logic          mis, mis_push, grant, accepted, credit;
  logic          rsp_any, rsp_drop, rsp_hit, push, pop;
  logic [SW-1:0] used;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic f_fault [FIFO_DEPTH];
  assign mis = (pc[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // Space freed by this cycle's pop is usable now: a new grant cannot be answered before the next edge.
  assign pop    = (f_cnt != '0) && bus.id_ready;
  assign used   = SW'(tq_cnt) + SW'(d_cnt) + SW'(f_cnt) - SW'(pop);
  assign credit = (used < SW'(FIFO_DEPTH));

  assign bus.imem_req  = rst_n && !redirect && credit && !mis;
  assign bus.imem_addr = pc;
  assign grant         = bus.imem_req && bus.imem_gnt;
  assign mis_push      = rst_n && !redirect && credit && mis && (tq_cnt == '0) && (d_cnt == '0);
  assign accepted      = grant || mis_push;

  always_comb begin
    next_pc = pc;
    if (rst_n) begin
      if (redirect)      next_pc = redirect_pc;
      else if (accepted) next_pc = pc + 32'd4;
    end
  end

  // Stale responses (counted in d_cnt) always precede those of live tags.
  assign rsp_any  = bus.imem_rvalid && ((d_cnt != '0) || (tq_cnt != '0));
  assign rsp_drop = bus.imem_rvalid && (d_cnt != '0);
  assign rsp_hit  = bus.imem_rvalid && (d_cnt == '0) && (tq_cnt != '0);
  assign push     = rsp_hit || mis_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tq_wr  <= '0;
      tq_rd  <= '0;
      tq_cnt <= '0;
      f_wr   <= '0;
      f_rd   <= '0;
      f_cnt  <= '0;
      d_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tq_addr[i] <= '0;
        f_instr[i] <= '0;
        f_pc[i]    <= '0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        f_fault[i] <= 1'b0;
`endif
      end
    end else if (redirect) begin
      tq_wr  <= '0;
      tq_rd  <= '0;
      tq_cnt <= '0;
      f_wr   <= '0;
      f_rd   <= '0;
      f_cnt  <= '0;
      d_cnt  <= d_cnt + tq_cnt - CW'(rsp_any);
    end else begin
      if (grant) begin
        tq_addr[tq_wr] <= pc;
        tq_wr          <= tq_wr + PW'(1);
      end
      if (rsp_hit) tq_rd <= tq_rd + PW'(1);
      tq_cnt <= tq_cnt + CW'(grant) - CW'(rsp_hit);
      if (rsp_drop) d_cnt <= d_cnt - CW'(1);
      if (push) begin
        f_instr[f_wr] <= mis_push ? 32'd0 : bus.imem_rdata;
        f_pc[f_wr]    <= mis_push ? pc : tq_addr[tq_rd];
`ifdef IFETCH_MISALIGN_CHECK_EN
        f_fault[f_wr] <= mis_push;
`endif
        f_wr <= f_wr + PW'(1);
      end
      if (pop) f_rd <= f_rd + PW'(1);
      f_cnt <= f_cnt + CW'(push) - CW'(pop);
    end
  end

  assign bus.id_valid = (f_cnt != '0);
  assign bus.id_instr = f_instr[f_rd];
  assign bus.id_pc    = f_pc[f_rd];
`ifdef IFETCH_MISALIGN_CHECK_EN
  assign bus.id_fault = f_fault[f_rd];
`else
  assign bus.id_fault = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
// tb_ifetch : directed self-checking bench; the bench acts as PC register and
//             as an in-order instruction memory with one-cycle latency
// Rev 1.0
// ============================================================================
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        rsp_en;
  logic [31:0] rq [$];
  int          checks   = 0;
  int          failures = 0;
  int          grants   = 0;

  ifetch_if bus();

  ifetch #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: latch next_pc into pc, record grants, replay responses in order.
  task automatic cycle();
    logic [31:0] np;
    logic [31:0] ga;
    logic        g;
    np = next_pc;
    g  = bus.imem_req && bus.imem_gnt;
    ga = bus.imem_addr;
    @(posedge clk);
    #1;
    pc = np;
    if (g) begin
      grants++;
      rq.push_back(ga);
    end
    if (rsp_en && rq.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mdata(rq.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst_n           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'd0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.id_ready    = 1'b0;
    rsp_en          = 1'b0;
    rq.delete();
    @(posedge clk);
    #1;
    pc     = start_pc;
    rst_n  = 1'b1;
    grants = 0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.id_valid && n < 20) begin
      cycle();
      n++;
    end
    chk(tag, 32'(bus.id_valid), 32'd1);
  endtask

  initial begin
    // Reset state, with redirect asserted to show next_pc still follows pc
    rst_n           = 1'b0;
    pc              = 32'h0000_1234;
    redirect        = 1'b1;
    redirect_pc     = 32'h0000_0500;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1111_2222;
    bus.id_ready    = 1'b1;
    rsp_en          = 1'b0;
    #2;
    chk("rst_req",     32'(bus.imem_req), 32'd0);
    chk("rst_valid",   32'(bus.id_valid), 32'd0);
    chk("rst_instr",   bus.id_instr,      32'd0);
    chk("rst_idpc",    bus.id_pc,         32'd0);
    chk("rst_fault",   32'(bus.id_fault), 32'd0);
    chk("rst_next_pc", next_pc,           32'h0000_1234);

    // Streaming fetch from 0 with one-cycle memory latency
    do_reset(32'd0);
    bus.imem_gnt = 1'b1; bus.id_ready = 1'b1; rsp_en = 1'b1;
    #1;
    chk("s1_c0_req",  32'(bus.imem_req), 32'd1);
    chk("s1_c0_npc",  next_pc,           32'd4);
    cycle();
    chk("s1_c1_npc",  next_pc,           32'd8);
    chk("s1_c1_vld",  32'(bus.id_valid), 32'd0);
    cycle();
    chk("s1_c2_vld",  32'(bus.id_valid), 32'd1);
    chk("s1_c2_idpc", bus.id_pc,         32'd0);
    chk("s1_c2_ins",  bus.id_instr,      mdata(32'd0));
    chk("s1_c2_npc",  next_pc,           32'h0000_000C);
    cycle();
    chk("s1_c3_idpc", bus.id_pc,         32'd4);
    chk("s1_c3_npc",  next_pc,           32'h0000_0010);
    cycle();
    chk("s1_c4_idpc", bus.id_pc,         32'd8);
    chk("s1_c4_ins",  bus.id_instr,      mdata(32'd8));

    // Decode stalled: credit limits to two grants, then one request per pop
    do_reset(32'h0000_0040);
    bus.imem_gnt = 1'b1; bus.id_ready = 1'b0; rsp_en = 1'b1;
    #1;
    repeat (5) cycle();
    chk("s2_grants",  32'(grants),       32'd2);
    chk("s2_req",     32'(bus.imem_req), 32'd0);
    chk("s2_npc",     next_pc,           32'h0000_0048);
    chk("s2_idpc",    bus.id_pc,         32'h0000_0040);
    bus.id_ready = 1'b1;
    #1;
    chk("s2_pop_req", 32'(bus.imem_req), 32'd1);
    chk("s2_pop_npc", next_pc,           32'h0000_004C);
    cycle();
    chk("s2_idpc2",   bus.id_pc,         32'h0000_0044);
    chk("s2_grants3", 32'(grants),       32'd3);

    // Redirect with two requests outstanding: stale responses are dropped
    do_reset(32'd0);
    bus.imem_gnt = 1'b1; bus.id_ready = 1'b1; rsp_en = 1'b0;
    #1;
    cycle();
    cycle();
    chk("s3_full_req", 32'(bus.imem_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    chk("s3_rd_npc",   next_pc,           32'h0000_0100);
    cycle();
    redirect = 1'b0;
    rsp_en   = 1'b1;
    #1;
    chk("s3_vld_after", 32'(bus.id_valid), 32'd0);
    chk("s3_disc_req",  32'(bus.imem_req), 32'd0);
    wait_valid("s3_wait_valid");
    chk("s3_idpc",      bus.id_pc,         32'h0000_0100);
    chk("s3_ins",       bus.id_instr,      mdata(32'h0000_0100));

    // Grant withheld: address and next_pc hold; spurious rvalid is ignored
    do_reset(32'h0000_0020);
    bus.imem_gnt = 1'b0; bus.id_ready = 1'b1; rsp_en = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("s4_req",  32'(bus.imem_req), 32'd1);
      chk("s4_addr", bus.imem_addr,     32'h0000_0020);
      chk("s4_npc",  next_pc,           32'h0000_0020);
      cycle();
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h5555_5555;
    #1;
    cycle();
    chk("s4_spur_vld", 32'(bus.id_valid), 32'd0);
    bus.imem_gnt = 1'b1;
    #1;
    cycle();
    bus.imem_gnt = 1'b0;
    #1;
    cycle();
    chk("s4_vld",  32'(bus.id_valid), 32'd1);
    chk("s4_idpc", bus.id_pc,         32'h0000_0020);
    chk("s4_ins",  bus.id_instr,      mdata(32'h0000_0020));
    chk("s4_grants", 32'(grants),     32'd1);

    // PC wrap at the top of the address space
    do_reset(32'hFFFF_FFFC);
    bus.imem_gnt = 1'b1; bus.id_ready = 1'b1; rsp_en = 1'b1;
    #1;
    chk("s5_wrap_npc", next_pc, 32'd0);
    cycle();
    chk("s5_after_npc", next_pc, 32'd4);

    // Redirect to a misaligned target
    do_reset(32'h0000_0200);
    bus.imem_gnt = 1'b1; bus.id_ready = 1'b1; rsp_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    #1;
    chk("s6_rd_req", 32'(bus.imem_req), 32'd0);
    cycle();
    redirect = 1'b0;
    #1;
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("s6_mis_req", 32'(bus.imem_req), 32'd0);
    wait_valid("s6_wait_valid");
    chk("s6_idpc",  bus.id_pc,         32'h0000_0102);
    chk("s6_fault", 32'(bus.id_fault), 32'd1);
    chk("s6_ins",   bus.id_instr,      32'd0);
`else
    chk("s6_req",  32'(bus.imem_req), 32'd1);
    chk("s6_addr", bus.imem_addr,     32'h0000_0102);
    wait_valid("s6_wait_valid");
    chk("s6_idpc",  bus.id_pc,         32'h0000_0102);
    chk("s6_fault", 32'(bus.id_fault), 32'd0);
    chk("s6_ins",   bus.id_instr,      mdata(32'h0000_0102));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, the fetch buffer entries (power of two, ≥2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port pc  input  32  current PC from the PC register.
REQ-005 SHALL have port next_pc  output  32  value loaded into the PC register next edge.
REQ-006 SHALL have port redirect  input  1  branch/jump taken; pulse for one cycle.
REQ-007 SHALL have port redirect_pc  input  32  redirect target.
REQ-008 SHALL have port imem_req  output  1  instruction-memory request.
REQ-009 SHALL have port imem_addr  output  32  request address.
REQ-010 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid  input  1  read data valid.
REQ-012 SHALL have port imem_rdata  input  32  read data.
REQ-013 SHALL have port id_valid  output  1  instruction available to decode.
REQ-014 SHALL have port id_ready  input  1  decode accepts instruction.
REQ-015 SHALL have port id_instr  output  32  instruction to decode.
REQ-016 SHALL have port id_pc  output  32  address of id_instr.
REQ-017 SHALL have port id_fault  output  1  misaligned-fetch flag for id_instr.

Function
REQ-018 SHALL drive imem_addr = pc and imem_req = 1 when credit exists (outstanding + FIFO occupancy < FIFO_DEPTH) and redirect = 0; else imem_req = 0.
REQ-019 SHALL count a request as accepted only when imem_req && imem_gnt in the same cycle.
REQ-020 SHALL drive next_pc combinationally: redirect ? redirect_pc : accepted ? pc+4 (mod 2^32, wraps 0xFFFFFFFC -> 0) : pc.
REQ-021 SHALL hold imem_addr stable while imem_req is high and unaccepted, unless redirect occurs.
REQ-022 SHALL record each accepted address in an in-order tag queue of FIFO_DEPTH entries; responses are in order, earliest one cycle after grant.
REQ-023 SHALL write each non-discarded response (imem_rdata, matching tag) into the fetch FIFO; id_valid rises the cycle after imem_rvalid (grant N -> rvalid ≥N+1 -> id_valid ≥N+2).
REQ-024 SHALL present the FIFO head on id_instr/id_pc/id_fault with id_valid = FIFO non-empty; pop on id_valid && id_ready.
REQ-025 SHALL support push and pop in the same cycle, occupancy unchanged.
REQ-026 SHALL never overflow the FIFO; the credit rule guarantees space for every outstanding response.
REQ-027 SHALL, on redirect, empty the FIFO and tag queue at that edge, load discard count = outstanding requests not yet answered (including a response arriving that cycle is excluded from the FIFO), and deassert id_valid the following cycle.
REQ-028 SHALL drop each imem_rvalid while discard count > 0 and decrement the count; FIFO writes resume when it reaches 0.
REQ-029 SHALL include discard count in the outstanding term of the credit rule.
REQ-030 SHALL ignore imem_rvalid when no request is outstanding.
REQ-031 SHALL treat a redirect coinciding with an id pop or a grant as redirect-only: the pop is harmless, the grant counts as outstanding and its response is discarded.

Reset
REQ-032 SHALL, while rst_n = 0, force imem_req = 0, id_valid = 0, id_instr = 0, id_pc = 0, id_fault = 0, FIFO/tag queue empty, all counters 0.
REQ-033 SHALL drop responses to requests granted before a reset; state restarts as after power-up.
REQ-034 SHALL drive next_pc = pc during reset.

Configuration
REQ-035 SHALL, with macro IFETCH_MISALIGN_CHECK_EN defined, set id_fault = 1 for entries whose id_pc[1:0] != 0 and deassert imem_req while pc[1:0] != 0 (that entry is enqueued directly without a memory access, id_instr = 0).
REQ-036 SHALL, without IFETCH_MISALIGN_CHECK_EN, tie id_fault = 0 and fetch any pc unchanged.

Verification
REQ-037 Reset release, pc=0, gnt=1, rvalid one cycle later, id_ready=1 -> id_pc 0,4,8 on consecutive cycles from cycle 3; next_pc = pc+4 each cycle.
REQ-038 id_ready=0, FIFO_DEPTH=2 -> exactly 2 grants, then imem_req=0 and next_pc=pc; id_ready=1 -> one new request per pop.
REQ-039 Two outstanding, redirect to 0x100 -> next_pc=0x100, id_valid=0 next cycle, both stale responses dropped, first id_pc=0x100.
REQ-040 imem_gnt=0 for 3 cycles with pc=0x20 -> imem_addr 0x20 stable, next_pc=0x20, no tag recorded.
REQ-041 pc=0xFFFFFFFC granted -> next_pc=0x00000000.
REQ-042 With IFETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> no imem_req, id_valid with id_fault=1, id_pc=0x102; without it -> imem_addr=0x102, id_fault=0.
